// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the sequencer state type.
// Used by the instruction decoder and the multicycle sequencer.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'd0;

  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } seq_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational R-type decoder: maps opcode/funct to an ALU select
// and flags whether the instruction is one the sequencer supports.
module instr_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_AND;
    legal  = 1'b0;
    if (opcode == OPC_RTYPE) begin
      unique case (funct)
        FN_AND: begin alu_op = ALU_AND; legal = 1'b1; end
        FN_OR:  begin alu_op = ALU_OR;  legal = 1'b1; end
        FN_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
        FN_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
        FN_SLT: begin alu_op = ALU_SLT; legal = 1'b1; end
        default: begin alu_op = ALU_AND; legal = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle fetch/decode/execute/writeback sequencer for R-type ALU ops.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [4:0]          rs_addr,
  output logic [4:0]          rt_addr,
  output logic [4:0]          rd_addr,
  output logic [2:0]          alu_op,
  output logic                reg_write,
  output logic                illegal,
  output logic                busy,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         retired_count
);

  seq_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [2:0]          alu_op_q, alu_op_d;

  logic [2:0]          dec_alu_op;
  logic                dec_legal;
  logic [4:0]          unused_shamt;

  instr_decoder u_dec (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // Request, write-enable and illegal strobes are pure functions of state,
  // so an asynchronous reset drops them in the same cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    imem_req  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!halt) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          alu_op_d = dec_alu_op;
          state_d  = ST_EXECUTE;
        end else begin
          illegal = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(PC_STEP);
          state_d = halt ? ST_IDLE : ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        reg_write = (ir_q[15:11] != 5'd0);
        pc_d      = pc_q + PC_WIDTH'(PC_STEP);
        state_d   = halt ? ST_IDLE : ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      alu_op_q <= ALU_AND;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      alu_op_q <= alu_op_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (state_q == ST_WRITEBACK) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= 32'd0;
    else        retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = 32'd0;
`endif

  // Shift amount is not used by any supported instruction.
  assign unused_shamt = ir_q[10:6];

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign rs_addr   = ir_q[25:21];
  assign rt_addr   = ir_q[20:16];
  assign rd_addr   = ir_q[15:11];
  assign alu_op    = alu_op_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios with literal
// expectations, then randomized instruction traffic against a behavioural model.
module tb_multicycle_sequencer;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    int          delay;
    logic [31:0] word;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;

  logic        imem_req, reg_write, illegal, busy;
  logic [31:0] imem_addr, pc, retired_count;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [2:0]  alu_op;

  logic        b_imem_req, b_reg_write, b_illegal, b_busy;
  logic [31:0] b_imem_addr, b_pc, b_retired_count;
  logic [4:0]  b_rs_addr, b_rt_addr, b_rd_addr;
  logic [2:0]  b_alu_op;

  int    checks = 0;
  int    errors = 0;
  bit    cmp_en = 1'b0;
  item_t stim_q[$];

  // Behavioural model: where the instruction is in its life, not a state encoding.
  bit          m_idle  = 1'b1;
  bit          m_fetch = 1'b0;
  int          m_since_ack = 0;
  logic [31:0] m_ir  = 32'd0;
  logic [2:0]  m_alu = 3'b000;
  logic [31:0] m_pc  = 32'd0;
  logic [31:0] m_ret = 32'd0;

  multicycle_sequencer #(.PC_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .alu_op(alu_op),
    .reg_write(reg_write), .illegal(illegal), .busy(busy), .pc(pc), .retired_count(retired_count)
  );

  multicycle_sequencer #(.PC_WIDTH(32), .PC_STEP(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs_addr(b_rs_addr), .rt_addr(b_rt_addr), .rd_addr(b_rd_addr), .alu_op(b_alu_op),
    .reg_write(b_reg_write), .illegal(b_illegal), .busy(b_busy), .pc(b_pc), .retired_count(b_retired_count)
  );

  always #5 clk = ~clk;

  // Returns {legal, alu select} straight from the supported-instruction table.
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    if (w[31:26] != 6'd0) return 4'b0000;
    case (w[5:0])
      6'd36:   return {1'b1, 3'b000};
      6'd37:   return {1'b1, 3'b001};
      6'd32:   return {1'b1, 3'b010};
      6'd34:   return {1'b1, 3'b110};
      6'd42:   return {1'b1, 3'b111};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_ret(input logic [31:0] n);
    return PERF ? n : 32'd0;
  endfunction

  // Advance the model by one clock from the inputs seen at the edge.
  always @(posedge clk or negedge rst_n) begin
    logic [3:0] d;
    bit         done;
    if (!rst_n) begin
      m_idle = 1'b1; m_fetch = 1'b0; m_since_ack = 0;
      m_ir = 32'd0; m_alu = 3'b000; m_pc = 32'd0; m_ret = 32'd0;
    end else begin
      done = 1'b0;
      d    = ref_decode(m_ir);
      if (m_idle) begin
        if (!halt) begin m_idle = 1'b0; m_fetch = 1'b1; end
      end else if (m_fetch) begin
        if (imem_ack) begin m_ir = imem_rdata; m_fetch = 1'b0; m_since_ack = 1; end
      end else if (m_since_ack == 1) begin
        if (d[3]) begin m_alu = d[2:0]; m_since_ack = 2; end
        else begin m_pc = m_pc + 32'd4; done = 1'b1; end
      end else if (m_since_ack == 2) begin
        m_since_ack = 3;
      end else begin
        m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1; done = 1'b1;
      end
      if (done) begin
        m_since_ack = 0;
        if (halt) m_idle = 1'b1;
        else      m_fetch = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int delay);
    item_t it;
    it.word  = word;
    it.delay = delay;
    stim_q.push_back(it);
  endtask

  function automatic logic [31:0] random_word();
    logic [5:0] fn_tab [5];
    int         r;
    logic [31:0] w;
    fn_tab = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42};
    r = $urandom_range(0, 9);
    w = $urandom;
    if (r <= 6)      begin w[31:26] = 6'd0; w[5:0] = fn_tab[$urandom_range(0, 4)]; end
    else if (r == 7) begin w[31:26] = 6'($urandom_range(1, 63)); end
    else if (r == 8) begin w[31:26] = 6'd0; w[5:0] = 6'd33; end
    else begin w[31:26] = 6'd0; w[15:11] = 5'd0; w[5:0] = fn_tab[$urandom_range(0, 4)]; end
    return w;
  endfunction

  // Per-cycle comparison of every meaningful output against the model.
  initial begin
    logic [3:0] d;
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        d = ref_decode(m_ir);
        checkOutput("m_busy", 32'(busy), 32'(!m_idle));
        checkOutput("m_imem_req", 32'(imem_req), 32'(m_fetch));
        if (m_fetch) checkOutput("m_imem_addr", imem_addr, m_pc);
        checkOutput("m_illegal", 32'(illegal), 32'(m_since_ack == 1 && !d[3]));
        checkOutput("m_reg_write", 32'(reg_write), 32'(m_since_ack == 3 && m_ir[15:11] != 5'd0));
        checkOutput("m_rs_addr", 32'(rs_addr), 32'(m_ir[25:21]));
        checkOutput("m_rt_addr", 32'(rt_addr), 32'(m_ir[20:16]));
        checkOutput("m_rd_addr", 32'(rd_addr), 32'(m_ir[15:11]));
        checkOutput("m_alu_op", 32'(alu_op), 32'(m_alu));
        checkOutput("m_pc", pc, m_pc);
        checkOutput("m_retired", retired_count, exp_ret(m_ret));
      end
    end
  end

  // Memory responder: acks each fetch after the queued (or random) number of wait cycles.
  initial begin
    bit          active = 1'b0;
    int          wcnt = 0;
    int          cur_delay = 0;
    logic [31:0] cur_word = 32'd0;
    item_t       it;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        active   = 1'b0;
      end else begin
        if (!active) begin
          if (stim_q.size() > 0) begin
            it = stim_q.pop_front();
            cur_delay = it.delay;
            cur_word  = it.word;
          end else begin
            cur_delay = $urandom_range(0, 3);
            cur_word  = random_word();
          end
          wcnt   = 0;
          active = 1'b1;
        end
        if (wcnt == cur_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = cur_word;
          active     = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
        end
        wcnt++;
      end
    end
  end

  initial begin
    int n;
    @(negedge clk);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_retired", retired_count, 32'd0);
    checkOutput("rst_wrap_pc", b_pc, 32'hFFFF_FFFC);

    applyStimulus(32'h0022_1820, 0);
    applyStimulus(32'h0022_1822, 5);
    applyStimulus(32'h8C43_0004, 0);
    applyStimulus(32'h0022_0025, 1);

    @(negedge clk);
    #3 rst_n  = 1'b1;
    cmp_en = 1'b1;

    // ADD $3,$1,$2 with zero-wait ack
    @(negedge clk);
    checkOutput("add_imem_req", 32'(imem_req), 32'd1);
    checkOutput("add_imem_addr", imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("add_reg_write", 32'(reg_write), 32'd1);
    checkOutput("add_rd_addr", 32'(rd_addr), 32'd3);
    checkOutput("add_alu_op", 32'(alu_op), 32'b010);
    @(negedge clk);
    checkOutput("add_pc", pc, 32'h4);
    checkOutput("add_retired", retired_count, exp_ret(1));
    checkOutput("wrap_pc", b_pc, 32'h0);

    // SUB with five wait cycles
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("sub_wait_req", 32'(imem_req), 32'd1);
      checkOutput("sub_wait_addr", imem_addr, 32'h4);
    end
    repeat (3) @(negedge clk);
    checkOutput("sub_reg_write", 32'(reg_write), 32'd1);
    checkOutput("sub_alu_op", 32'(alu_op), 32'b110);
    @(negedge clk);
    checkOutput("sub_pc", pc, 32'h8);

    // lw is unsupported
    @(negedge clk);
    checkOutput("lw_illegal", 32'(illegal), 32'd1);
    checkOutput("lw_reg_write", 32'(reg_write), 32'd0);
    @(negedge clk);
    checkOutput("lw_illegal_gone", 32'(illegal), 32'd0);
    checkOutput("lw_pc", pc, 32'hC);
    checkOutput("lw_retired", retired_count, exp_ret(2));

    // OR with rd=0
    repeat (4) @(negedge clk);
    checkOutput("or_rd0_reg_write", 32'(reg_write), 32'd0);
    checkOutput("or_rd0_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    checkOutput("or_rd0_pc", pc, 32'h10);
    checkOutput("or_rd0_retired", retired_count, exp_ret(3));

    // halt raised while a delayed fetch is in flight
    applyStimulus(32'h0085_3020, 3);
    #2 halt = 1'b1;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("halt_busy", 32'(busy), 32'd0);
    checkOutput("halt_imem_req", 32'(imem_req), 32'd0);
    checkOutput("halt_pc", pc, 32'h14);
    checkOutput("halt_retired", retired_count, exp_ret(4));
    repeat (3) @(negedge clk);
    checkOutput("halt_still_idle", 32'(busy), 32'd0);
    applyStimulus(32'h0022_1820, 6);
    #2 halt = 1'b0;
    @(negedge clk);
    checkOutput("resume_imem_req", 32'(imem_req), 32'd1);
    checkOutput("resume_imem_addr", imem_addr, 32'h14);

    // asynchronous reset in the middle of a fetch handshake
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("arst_pc", pc, 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_wrap_pc", b_pc, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // randomized traffic with sporadic halt
    for (int i = 0; i < 300; i++) applyStimulus(random_word(), $urandom_range(0, 3));
    n = 0;
    while (stim_q.size() > 0 && n < 20000) begin
      @(negedge clk);
      #2;
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      n++;
    end
    checkOutput("random_queue_drained", 32'(stim_q.size()), 32'd0);
    halt = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
